// File: rtl/clk_pkg.sv
// Shared types and default timing constants for the digital-clock time-setting logic.
package clk_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } mode_t;

  localparam int DEB_CYCLES_DEF = 4;
  localparam int REPEAT_DLY_DEF = 8;
  localparam int REPEAT_PER_DEF = 4;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_btn_debounce.sv
// One push-button path: 2-FF synchronizer, stability counter, debounced level
// and a one-cycle press pulse on the level's rising edge.
module clk_btn_debounce
  import clk_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic CLK,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;

  logic          sync1_reg;
  logic          sync2_reg;
  logic          level_reg;
  logic          level_d_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      level_reg   <= 1'b0;
      level_d_reg <= 1'b0;
      cnt_reg     <= '0;
    end else begin
      sync1_reg   <= btn;
      sync2_reg   <= sync1_reg;
      level_d_reg <= level_reg;
      // Level flips on the DEB_CYCLES-th consecutive disagreeing sample.
      if (sync2_reg != level_reg) begin
        if (cnt_reg == CW'(DEB_CYCLES - 1)) begin
          level_reg <= ~level_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CW'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;
  assign press = level_reg & ~level_d_reg;

endmodule

// File: rtl/clk_time_set_ctrl.sv
// Mode machine, increment auto-repeat and registered counter-control pulses
// for setting the time of the digital clock.
module clk_time_set_ctrl
  import clk_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int REPEAT_DLY = REPEAT_DLY_DEF,
  parameter int REPEAT_PER = REPEAT_PER_DEF
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_clr,
  input  logic       min_carry,
  output logic       count_up_hr,
  output logic       count_up_min,
  output logic       rst_counters,
  output logic       run_en,
  output logic [1:0] mode
);

  localparam int RW = $clog2(max_int(REPEAT_DLY, REPEAT_PER)) + 1;

  mode_t         state_reg, state_next;
  logic [RW-1:0] rep_cnt_reg, rep_cnt_next;
  logic          rep_phase_reg, rep_phase_next;   // 0: waiting first delay, 1: periodic
  logic          rep_armed_reg, rep_armed_next;   // set only by a press seen in a set mode
  logic          hr_reg, hr_next;
  logic          min_reg, min_next;
  logic          clr_reg, clr_next;
  logic          run_en_reg, run_en_next;
  logic          mode_press, inc_press, clr_press, inc_level;
  logic          unused_mode_level, unused_clr_level;
  logic          rep_due;

  clk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
    .CLK(CLK), .rst_n(rst_n), .btn(btn_mode), .level(unused_mode_level), .press(mode_press)
  );
  clk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_inc (
    .CLK(CLK), .rst_n(rst_n), .btn(btn_inc), .level(inc_level), .press(inc_press)
  );
  clk_btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .CLK(CLK), .rst_n(rst_n), .btn(btn_clr), .level(unused_clr_level), .press(clr_press)
  );

  always_comb begin
    state_next     = state_reg;
    rep_cnt_next   = rep_cnt_reg;
    rep_phase_next = rep_phase_reg;
    rep_armed_next = rep_armed_reg;
    hr_next        = 1'b0;
    min_next       = 1'b0;
    clr_next       = clr_press;
    rep_due        = 1'b0;

    case (state_reg)
      RUN: begin
        hr_next        = min_carry;
        rep_cnt_next   = '0;
        rep_phase_next = 1'b0;
        rep_armed_next = 1'b0;
        if (mode_press) state_next = SET_HR;
      end
      SET_HR, SET_MIN: begin
        rep_due = rep_armed_reg && inc_level &&
                  ((!rep_phase_reg && rep_cnt_reg == RW'(REPEAT_DLY)) ||
                   ( rep_phase_reg && rep_cnt_reg == RW'(REPEAT_PER)));
        if (mode_press) begin
          // Mode change wins; a held increment must be re-pressed to act again.
          state_next     = (state_reg == SET_HR) ? SET_MIN : RUN;
          rep_cnt_next   = '0;
          rep_phase_next = 1'b0;
          rep_armed_next = 1'b0;
        end else if (inc_press || rep_due) begin
          rep_cnt_next = RW'(1);
          if (clr_press || inc_press) begin
            rep_phase_next = 1'b0;
            rep_armed_next = 1'b1;
          end else begin
            rep_phase_next = 1'b1;
          end
          if (!clr_press) begin
            hr_next  = (state_reg == SET_HR);
            min_next = (state_reg == SET_MIN);
          end
        end else if (!inc_level) begin
          rep_cnt_next   = '0;
          rep_phase_next = 1'b0;
          rep_armed_next = 1'b0;
        end else if (rep_armed_reg) begin
          rep_cnt_next = rep_cnt_reg + RW'(1);
        end
      end
      default: begin
        state_next     = RUN;
        rep_cnt_next   = '0;
        rep_phase_next = 1'b0;
        rep_armed_next = 1'b0;
      end
    endcase

    run_en_next = (state_next == RUN);
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RUN;
      rep_cnt_reg   <= '0;
      rep_phase_reg <= 1'b0;
      rep_armed_reg <= 1'b0;
      hr_reg        <= 1'b0;
      min_reg       <= 1'b0;
      clr_reg       <= 1'b0;
      run_en_reg    <= 1'b1;
    end else begin
      state_reg     <= state_next;
      rep_cnt_reg   <= rep_cnt_next;
      rep_phase_reg <= rep_phase_next;
      rep_armed_reg <= rep_armed_next;
      hr_reg        <= hr_next;
      min_reg       <= min_next;
      clr_reg       <= clr_next;
      run_en_reg    <= run_en_next;
    end
  end

  assign count_up_hr  = hr_reg;
  assign count_up_min = min_reg;
  assign rst_counters = clr_reg;
  assign run_en       = run_en_reg;
  assign mode         = state_reg;

endmodule

// File: tb/tb_clk_time_set_ctrl.sv
// Scenario bench for clk_time_set_ctrl: expected output pulses are queued with
// their cycle number and matched by a monitor as the DUT emits them.
module tb_clk_time_set_ctrl;

  localparam int D   = 4;
  localparam int DLY = 8;
  localparam int PER = 4;

  localparam logic [2:0] K_HR  = 3'b001;
  localparam logic [2:0] K_MIN = 3'b010;
  localparam logic [2:0] K_CLR = 3'b100;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_clr = 1'b0, min_carry = 1'b0;
  logic       count_up_hr, count_up_min, rst_counters, run_en;
  logic [1:0] mode;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } exp_t;
  exp_t exp_q[$];

  clk_time_set_ctrl #(.DEB_CYCLES(D), .REPEAT_DLY(DLY), .REPEAT_PER(PER)) dut (
    .CLK(CLK), .rst_n(rst_n), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_clr(btn_clr),
    .min_carry(min_carry), .count_up_hr(count_up_hr), .count_up_min(count_up_min),
    .rst_counters(rst_counters), .run_en(run_en), .mode(mode)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Every pulse the DUT emits must match the oldest queued expectation.
  always @(negedge CLK) begin : monitor
    logic [2:0] got;
    exp_t       e;
    got = {rst_counters, count_up_min, count_up_hr};
    if (got != 3'b000) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pulse_unexpected: cycle %0d got kind %b, required no pulse", cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.kind !== got) begin
          errors++;
          $display("FAIL pulse: cycle %0d kind %b, required cycle %0d kind %b", cyc, got, e.cyc, e.kind);
        end else begin
          $display("pulse cycle %0d kind %b ok", cyc, got);
        end
      end
    end
  end

  task automatic goto(input int t);
    while (cyc < t) @(negedge CLK);
  endtask

  task automatic press_mode();
    int k0;
    k0 = cyc + 1;
    btn_mode = 1'b1;
    goto(k0 + 7);
    btn_mode = 1'b0;
    goto(k0 + 16);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if ({count_up_hr, count_up_min, rst_counters, run_en, mode} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_hold: got hr/min/clr/run/mode %b, required 000100",
               {count_up_hr, count_up_min, rst_counters, run_en, mode});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({count_up_hr, count_up_min, rst_counters, run_en, mode} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_release: got %b, required 000100",
               {count_up_hr, count_up_min, rst_counters, run_en, mode});
    end
    $display("test_reset done");
  endtask

  task automatic test_carry();
    int k0;
    goto(cyc + 9);
    k0 = cyc + 1;
    min_carry = 1'b1;
    exp_q.push_back('{k0, K_HR});
    @(negedge CLK);
    min_carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      checks++;
      if (run_en !== 1'b1 || mode !== 2'b00) begin
        errors++;
        $display("FAIL carry_run_state: run_en=%b mode=%b, required 1 00", run_en, mode);
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL carry_missing: %0d pulses left, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_carry done");
  endtask

  task automatic test_mode();
    int k0;
    logic [1:0] prev, want;
    prev = 2'b00;
    for (int p = 0; p < 3; p++) begin
      want = (p == 0) ? 2'b01 : (p == 1) ? 2'b10 : 2'b00;
      k0 = cyc + 1;
      btn_mode = 1'b1;
      goto(k0 + 5);
      checks++;
      if (mode !== prev) begin
        errors++;
        $display("FAIL mode_early: press %0d mode=%b, required %b", p, mode, prev);
      end
      goto(k0 + 6);
      checks++;
      if (mode !== want || run_en !== (want == 2'b00)) begin
        errors++;
        $display("FAIL mode_step: press %0d mode=%b run_en=%b, required %b %b",
                 p, mode, run_en, want, (want == 2'b00));
      end else begin
        $display("mode press %0d -> %b ok", p, mode);
      end
      goto(k0 + 8);
      btn_mode = 1'b0;
      goto(k0 + 17);
      prev = want;
    end
  endtask

  task automatic test_repeat();
    int k0, t, rel;
    press_mode();
    checks++;
    if (mode !== 2'b01 || run_en !== 1'b0) begin
      errors++;
      $display("FAIL repeat_enter: mode=%b run_en=%b, required 01 0", mode, run_en);
    end
    rel = 28;
    k0 = cyc + 1;
    btn_inc = 1'b1;
    exp_q.push_back('{k0 + 2 + D, K_HR});
    t = 2 + D + DLY;
    while (t - 1 < rel + 1 + D) begin
      exp_q.push_back('{k0 + t, K_HR});
      t += PER;
    end
    goto(k0 + rel - 1);
    btn_inc = 1'b0;
    goto(k0 + rel + 20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL repeat_missing: %0d pulses left, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_repeat done");
  endtask

  task automatic test_glitch_min();
    int k0;
    press_mode();
    checks++;
    if (mode !== 2'b10 || run_en !== 1'b0) begin
      errors++;
      $display("FAIL min_enter: mode=%b run_en=%b, required 10 0", mode, run_en);
    end
    btn_inc = 1'b1;
    repeat (3) @(negedge CLK);
    btn_inc = 1'b0;
    goto(cyc + 12);
    k0 = cyc + 1;
    btn_inc = 1'b1;
    exp_q.push_back('{k0 + 2 + D, K_MIN});
    goto(k0 + 6);
    btn_inc = 1'b0;
    goto(k0 + 16);
    min_carry = 1'b1;
    @(negedge CLK);
    min_carry = 1'b0;
    repeat (5) @(negedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL min_missing: %0d pulses left, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_glitch_min done");
  endtask

  task automatic test_clr_inc();
    int k0;
    press_mode();
    press_mode();
    k0 = cyc + 1;
    btn_clr = 1'b1;
    btn_inc = 1'b1;
    exp_q.push_back('{k0 + 2 + D, K_CLR});
    goto(k0 + 5);
    btn_clr = 1'b0;
    btn_inc = 1'b0;
    goto(k0 + 24);
    checks++;
    if (mode !== 2'b01) begin
      errors++;
      $display("FAIL clr_mode: mode=%b, required 01", mode);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL clr_missing: %0d pulses left, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_clr_inc done");
  endtask

  task automatic test_reset_mid();
    int k0;
    press_mode();
    k0 = cyc + 1;
    btn_inc = 1'b1;
    exp_q.push_back('{k0 + 2 + D, K_MIN});
    exp_q.push_back('{k0 + 2 + D + DLY, K_MIN});
    goto(k0 + 16);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({count_up_hr, count_up_min, rst_counters, run_en, mode} !== 6'b000100) begin
      errors++;
      $display("FAIL reset_mid: got %b, required 000100",
               {count_up_hr, count_up_min, rst_counters, run_en, mode});
    end
    goto(k0 + 18);
    rst_n = 1'b1;
    goto(k0 + 45);
    btn_inc = 1'b0;
    goto(cyc + 10);
    checks++;
    if (mode !== 2'b00 || run_en !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_run: mode=%b run_en=%b, required 00 1", mode, run_en);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_missing: %0d pulses left, required 0", exp_q.size());
      exp_q.delete();
    end
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_carry();
    test_mode();
    test_repeat();
    test_glitch_min();
    test_clr_inc();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
